gcd_reduce: RTL and testbench

- Downstream consumer of the gcd block.
- Takes the same operand pair fed to gcd (num1, num2) plus its gcd_out/DONE result, and reduces the ratio num1:num2 to lowest terms, num1/g : num2/g.
- Uses two parallel restoring dividers that share divisor g, one quotient bit per clock.
- Result is presented with a level done flag and an error flag for the downstream display/readout logic.

---
 rtl/gcd_reduce_if.sv | 25 ++
 rtl/gcd_reduce.sv | 134 +++++++++++++
 tb/tb_gcd_reduce.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/gcd_reduce_if.sv
// Operand/result bundle between the gcd stage and the ratio reducer.
// The master side drives operands and the gcd result; the slave side returns the reduced pair.
interface gcd_reduce_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] num1;
   logic [WIDTH-1:0] num2;
   logic [WIDTH-1:0] gcd_in;
   logic             gcd_done;
   logic [WIDTH-1:0] num_out;
   logic [WIDTH-1:0] den_out;
   logic             busy;
   logic             done;
   logic             err;

   modport master (
      output num1, num2, gcd_in, gcd_done,
      input  num_out, den_out, busy, done, err
   );

   modport slave (
      input  num1, num2, gcd_in, gcd_done,
      output num_out, den_out, busy, done, err
   );
endinterface

// File: rtl/gcd_reduce.sv
// Reduces num1:num2 to lowest terms by dividing both by the gcd result,
// using two restoring dividers that share one divisor and retire one quotient bit per clock.
module gcd_reduce #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input logic        clk,
   input logic        reset,
   gcd_reduce_if.slave bus
);

   typedef enum logic {IDLE, DIV} state_t;

   state_t state, state_nxt;

   logic [WIDTH-1:0] a_q, a_nxt, b_q, b_nxt, d_q, d_nxt;
   logic [WIDTH:0]   ra_q, ra_nxt, rb_q, rb_nxt;
   logic [CNT_W-1:0] count, count_nxt;
   logic [WIDTH-1:0] num_out_q, num_out_nxt, den_out_q, den_out_nxt;
   logic             busy_q, busy_nxt, done_q, done_nxt, err_q, err_nxt;
   logic             gcd_done_q, start;

   // One restoring step: returns {new remainder, new quotient/dividend shift register}.
   function automatic logic [2*WIDTH:0] div_step(input logic [WIDTH:0]   r,
                                                  input logic [WIDTH-1:0] q,
                                                  input logic [WIDTH-1:0] d);
      logic [WIDTH:0] sh;
      sh = {r[WIDTH-1:0], q[WIDTH-1]};
      if (sh >= {1'b0, d})
         return {sh - {1'b0, d}, q[WIDTH-2:0], 1'b1};
      else
         return {sh, q[WIDTH-2:0], 1'b0};
   endfunction

   assign start = bus.gcd_done & ~gcd_done_q;

   always_comb begin
      // NOTE: every variable gets a hold default first so no path leaves it unassigned (no latch).
      state_nxt   = state;
      a_nxt       = a_q;
      b_nxt       = b_q;
      d_nxt       = d_q;
      ra_nxt      = ra_q;
      rb_nxt      = rb_q;
      count_nxt   = count;
      num_out_nxt = num_out_q;
      den_out_nxt = den_out_q;
      busy_nxt    = busy_q;
      done_nxt    = done_q;
      err_nxt     = err_q;

      case (state)
         IDLE: begin
            if (start) begin
               a_nxt     = bus.num1;
               b_nxt     = bus.num2;
               d_nxt     = bus.gcd_in;
               ra_nxt    = '0;
               rb_nxt    = '0;
               count_nxt = '0;
               busy_nxt  = 1'b1;
               done_nxt  = 1'b0;
               err_nxt   = 1'b0;
               state_nxt = DIV;
            end
         end
         DIV: begin
            {ra_nxt, a_nxt} = div_step(ra_q, a_q, d_q);
            {rb_nxt, b_nxt} = div_step(rb_q, b_q, d_q);
            count_nxt       = count + CNT_W'(1);
            // A zero divisor finishes on the first DIV edge instead of running all iterations.
            if (d_q == '0) begin
               num_out_nxt = '0;
               den_out_nxt = '0;
               err_nxt     = 1'b1;
               done_nxt    = 1'b1;
               busy_nxt    = 1'b0;
               state_nxt   = IDLE;
            end else if (count == CNT_W'(WIDTH - 1)) begin
               num_out_nxt = a_nxt;
               den_out_nxt = b_nxt;
               err_nxt     = (ra_nxt != '0) | (rb_nxt != '0);
               done_nxt    = 1'b1;
               busy_nxt    = 1'b0;
               state_nxt   = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         a_q        <= '0;
         b_q        <= '0;
         d_q        <= '0;
         ra_q       <= '0;
         rb_q       <= '0;
         count      <= '0;
         num_out_q  <= '0;
         den_out_q  <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         gcd_done_q <= 1'b0;
      end else begin
         a_q        <= a_nxt;
         b_q        <= b_nxt;
         d_q        <= d_nxt;
         ra_q       <= ra_nxt;
         rb_q       <= rb_nxt;
         count      <= count_nxt;
         num_out_q  <= num_out_nxt;
         den_out_q  <= den_out_nxt;
         busy_q     <= busy_nxt;
         done_q     <= done_nxt;
         err_q      <= err_nxt;
         gcd_done_q <= bus.gcd_done;
      end
   end

   assign bus.num_out = num_out_q;
   assign bus.den_out = den_out_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.err     = err_q;

endmodule

// File: tb/tb_gcd_reduce.sv
// Self-checking bench for gcd_reduce: directed cases plus random operands
// compared against plain integer division and remainder.
module tb_gcd_reduce;

   localparam int WIDTH = 32;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   gcd_reduce_if #(.WIDTH(WIDTH)) bus ();

   gcd_reduce #(.WIDTH(WIDTH), .CNT_W(6)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Launch one reduction; glitch_at injects a second gcd_done edge at that DIV iteration,
   // abort_at asserts reset for one clock at that iteration.
   task automatic run_op(input logic [WIDTH-1:0] n1, input logic [WIDTH-1:0] n2,
                         input logic [WIDTH-1:0] g, input int glitch_at, input int abort_at);
      logic [WIDTH-1:0] exp_num, exp_den;
      logic             exp_err;
      int               exp_lat, lat;
      bit               seen;

      if (g == 0) begin
         exp_num = 0;
         exp_den = 0;
         exp_err = 1'b1;
         exp_lat = 1;
      end else begin
         exp_num = n1 / g;
         exp_den = n2 / g;
         exp_err = ((n1 % g) != 0) || ((n2 % g) != 0);
         exp_lat = WIDTH;
      end

      bus.num1     = n1;
      bus.num2     = n2;
      bus.gcd_in   = g;
      bus.gcd_done = 1'b1;
      tick();
      check("busy_e0", bus.busy, 1);
      check("done_e0", bus.done, 0);
      bus.num1   = $urandom;
      bus.num2   = $urandom;
      bus.gcd_in = $urandom;

      seen = 0;
      lat  = 0;
      for (int k = 1; k <= WIDTH + 4 && !seen; k++) begin
         if (glitch_at != 0 && k == glitch_at - 1) bus.gcd_done = 1'b0;
         if (glitch_at != 0 && k == glitch_at)     bus.gcd_done = 1'b1;
         if (abort_at != 0 && k == abort_at) begin
            reset        = 1'b1;
            bus.gcd_done = 1'b0;
         end
         tick();
         if (abort_at != 0 && k == abort_at) begin
            reset = 1'b0;
            check("abort_num", bus.num_out, 0);
            check("abort_den", bus.den_out, 0);
            check("abort_busy", bus.busy, 0);
            check("abort_done", bus.done, 0);
            check("abort_err", bus.err, 0);
            tick();
            return;
         end
         if (bus.done) begin
            seen = 1;
            lat  = k;
         end
      end

      if (!seen) begin
         check("timeout", 0, 1);
      end else begin
         check("latency", lat, exp_lat);
         check("num_out", bus.num_out, exp_num);
         check("den_out", bus.den_out, exp_den);
         check("err", bus.err, exp_err);
         check("busy_end", bus.busy, 0);
      end

      // gcd_done still high: a level must not retrigger, and the result holds.
      repeat (3) tick();
      check("hold_done", bus.done, 1);
      check("hold_busy", bus.busy, 0);
      check("hold_num", bus.num_out, exp_num);
      bus.gcd_done = 1'b0;
      tick();
   endtask

   initial begin
      logic [WIDTH-1:0] n1, n2, g;

      reset        = 1'b1;
      bus.num1     = 161;
      bus.num2     = 14;
      bus.gcd_in   = 7;
      bus.gcd_done = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      check("rst_num", bus.num_out, 0);
      check("rst_den", bus.den_out, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_err", bus.err, 0);
      #14;
      reset = 1'b0;
      tick();

      run_op(161, 14, 7, 0, 0);
      run_op(17, 5, 1, 0, 0);
      run_op(0, 0, 0, 0, 0);
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
      run_op(12, 8, 3, 0, 0);
      run_op(100, 75, 25, 0, 10);
      run_op(100, 75, 25, 0, 0);
      run_op(161, 14, 7, 5, 0);

      for (int i = 0; i < 8; i++) begin
         case ($urandom_range(0, 3))
            0:       g = 0;
            1:       g = $urandom;
            default: g = $urandom_range(1, 60);
         endcase
         if ($urandom_range(0, 2) != 0) begin
            n1 = g * $urandom_range(0, 5000);
            n2 = g * $urandom_range(1, 5000);
         end else begin
            n1 = $urandom;
            n2 = $urandom;
         end
         run_op(n1, n2, g, 0, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
